// File: rtl/sfifo_arb_pkg.sv
// sfifo_arb_pkg: shared types and helpers for the FIFO write arbiter.
//   arb_st_e : arbiter state (normal run plus the three flush steps)
//   MAX_REQ  : largest supported requester count
//   rr_pick  : round-robin one-hot pick over up to MAX_REQ requesters
package sfifo_arb_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FSH_DRAIN = 2'd1,
    FSH_PULSE = 2'd2,
    FSH_DONE  = 2'd3
  } arb_st_e;

  localparam int MAX_REQ = 8;

  // Scan n requesters starting at ptr, wrapping modulo n; returns a one-hot
  // grant for the first valid one, or zero. ptr must be below n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] vld,
                                                 input logic [2:0]         ptr,
                                                 input logic [3:0]         n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    logic [3:0]         idx;
    gnt   = {MAX_REQ{1'b0}};
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + k[3:0];
      // ptr < n and k < n, so a single wrap is enough
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if (!found && (k[3:0] < n) && vld[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sfifo_rr_pick.sv
// sfifo_rr_pick: combinational round-robin priority picker.
//   vld     : per-requester valid
//   ptr     : requester with highest priority this cycle
//   gnt     : one-hot grant (zero when nobody is valid)
//   gnt_idx : binary index of the granted requester (0 when no grant)
module sfifo_rr_pick
  import sfifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vld,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic [MAX_REQ-1:0] gnt_all;

  // Pick the winner and encode its index
  always_comb begin
    gnt_all = rr_pick(MAX_REQ'(vld), 3'(ptr), 4'(N_REQ));
    gnt     = gnt_all[N_REQ-1:0];
    gnt_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (gnt_all[i]) begin
        gnt_idx = ID_W'(i);
      end else begin
        gnt_idx = gnt_idx;
      end
    end
  end

endmodule

// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb: round-robin write arbiter and flush sequencer feeding the
// push port of a synchronous FIFO.
//   clk, rst            : clock and synchronous active-high reset
//   req_vld/req_dat     : requester valids and packed payloads
//   req_rdy             : combinational one-hot grant
//   fifo_we/fifo_wd     : registered push strobe and {id, payload}
//   fifo_fsh            : registered flush strobe
//   fifo_full/ovf/len   : FIFO status used for credit and error tracking
//   fsh_req/fsh_done    : flush request level and completion pulse
//   ovf_err             : sticky overflow error
module sfifo_wr_arb
  import sfifo_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 28,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int FIFO_W   = DATA_W + ID_W,
  parameter int FIFO_D   = 12,
  parameter int FIFO_ADR = $clog2(FIFO_D)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*DATA_W-1:0] req_dat,
  output logic [N_REQ-1:0]        req_rdy,
  output logic                    fifo_we,
  output logic [FIFO_W-1:0]       fifo_wd,
  output logic                    fifo_fsh,
  input  logic                    fifo_full,
  input  logic                    fifo_ovf,
  input  logic [FIFO_ADR:0]       fifo_len,
  input  logic                    fsh_req,
  output logic                    fsh_done,
  output logic                    ovf_err
);

  arb_st_e           state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              fifo_we_q, fifo_we_d;
  logic [FIFO_W-1:0] fifo_wd_q, fifo_wd_d;
  logic              fifo_fsh_q, fifo_fsh_d;
  logic              fsh_done_q, fsh_done_d;
  logic              ovf_err_q, ovf_err_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic [FIFO_ADR+1:0] occ_s;
  logic              space_ok;
  logic              gnt_en;
  logic              xfer;

  sfifo_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .vld     (req_vld),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Credit check and grant gating; the registered write not yet visible in
  // fifo_len is counted as occupied, pops are ignored
  always_comb begin
    occ_s    = {1'b0, fifo_len} + {{(FIFO_ADR+1){1'b0}}, fifo_we_q};
    space_ok = (occ_s < (FIFO_ADR+2)'(FIFO_D));
    gnt_en   = ~rst & (state_q == RUN) & ~fsh_req & space_ok & ~fifo_full;
    if (gnt_en) begin
      req_rdy = pick_gnt;
    end else begin
      req_rdy = '0;
    end
    xfer = |(req_vld & req_rdy);
  end

  // Next values for the write port, round-robin pointer and error flag
  always_comb begin
    fifo_we_d = xfer;
    if (xfer) begin
      fifo_wd_d = {pick_idx, req_dat[pick_idx*DATA_W +: DATA_W]};
    end else begin
      fifo_wd_d = fifo_wd_q;
    end
    if (xfer) begin
      if (pick_idx == ID_W'(N_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = pick_idx + ID_W'(1);
      end
    end else if (state_q == FSH_DONE) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    ovf_err_d = ovf_err_q | fifo_ovf | (fifo_we_q & fifo_full);
  end

  // Flush sequencer next state
  always_comb begin
    case (state_q)
      RUN: begin
        if (fsh_req) begin
          state_d = FSH_DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      FSH_DRAIN: state_d = FSH_PULSE;
      FSH_PULSE: state_d = FSH_DONE;
      FSH_DONE:  state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // Flush strobes are registered decodes of the state being entered
  always_comb begin
    fifo_fsh_d = (state_d == FSH_PULSE);
    fsh_done_d = (state_d == FSH_DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Output, pointer and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      fifo_we_q  <= 1'b0;
      fifo_wd_q  <= '0;
      fifo_fsh_q <= 1'b0;
      fsh_done_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      fifo_we_q  <= fifo_we_d;
      fifo_wd_q  <= fifo_wd_d;
      fifo_fsh_q <= fifo_fsh_d;
      fsh_done_q <= fsh_done_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign fifo_we  = fifo_we_q;
  assign fifo_wd  = fifo_wd_q;
  assign fifo_fsh = fifo_fsh_q;
  assign fsh_done = fsh_done_q;
  assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb_sfifo_wr_arb: randomized bench for sfifo_wr_arb with a cycle-level
// reference model and a simple FIFO occupancy emulation.
module tb_sfifo_wr_arb;

  localparam int N   = 4;
  localparam int DW  = 28;
  localparam int IDW = 2;
  localparam int FW  = DW + IDW;
  localparam int FD  = 12;
  localparam int ADR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_dat;
  logic [N-1:0]    req_rdy;
  logic            fifo_we;
  logic [FW-1:0]   fifo_wd;
  logic            fifo_fsh;
  logic            fifo_full;
  logic            fifo_ovf;
  logic [ADR:0]    fifo_len;
  logic            fsh_req;
  logic            fsh_done;
  logic            ovf_err;

  always #5 clk = ~clk;

  sfifo_wr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_dat   (req_dat),
    .req_rdy   (req_rdy),
    .fifo_we   (fifo_we),
    .fifo_wd   (fifo_wd),
    .fifo_fsh  (fifo_fsh),
    .fifo_full (fifo_full),
    .fifo_ovf  (fifo_ovf),
    .fifo_len  (fifo_len),
    .fsh_req   (fsh_req),
    .fsh_done  (fsh_done),
    .ovf_err   (ovf_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus knobs
  bit         s_rst, s_fsh, s_ovf, s_pop;
  bit [N-1:0] s_vld;

  // FIFO emulation
  int occ = 0;

  // reference model: phase 0 = run, 1 = drain, 2 = flush pulse, 3 = done
  int         m_ptr = 0;
  int         m_phase = 0;
  int         m_id;
  bit         m_we = 1'b0, m_fsh = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [FW-1:0] m_wd = '0;
  bit [N-1:0] exp_rdy;

  // observation counters for directed scenarios
  int we_cnt, fsh_cnt, done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst     = s_rst;
    req_vld = s_vld;
    fsh_req = s_fsh;
    fifo_ovf = s_ovf;
    for (int i = 0; i < N; i++) req_dat[i*DW +: DW] = DW'($urandom);
    fifo_len  = (ADR+1)'(occ);
    fifo_full = (occ >= FD);

    // expected grant: first valid from the pointer, if room and running
    exp_rdy = '0;
    m_id = -1;
    if (!s_rst && m_phase == 0 && !s_fsh && !fifo_full && (occ + int'(m_we)) < FD) begin
      for (int k = 0; k < N; k++) begin
        if (m_id < 0 && s_vld[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
      end
    end
    if (m_id >= 0) exp_rdy[m_id] = 1'b1;

    #1;
    chk("req_rdy",  32'(req_rdy),  32'(exp_rdy));
    chk("fifo_we",  32'(fifo_we),  32'(m_we));
    chk("fifo_wd",  32'(fifo_wd),  32'(m_wd));
    chk("fifo_fsh", 32'(fifo_fsh), 32'(m_fsh));
    chk("fsh_done", 32'(fsh_done), 32'(m_done));
    chk("ovf_err",  32'(ovf_err),  32'(m_err));
    if (fifo_we)  we_cnt++;
    if (fifo_fsh) fsh_cnt++;
    if (fsh_done) done_cnt++;

    @(posedge clk);
    // FIFO occupancy after this edge
    if (s_rst || m_fsh) begin
      occ = 0;
    end else begin
      if (s_pop && occ > 0) occ--;
      occ = occ + int'(m_we);
      if (occ > FD) occ = FD;
    end
    // model registers after this edge
    if (s_rst) begin
      m_ptr = 0; m_phase = 0; m_we = 0; m_wd = '0;
      m_fsh = 0; m_done = 0; m_err = 0;
    end else begin
      m_err = m_err | s_ovf | (m_we & fifo_full);
      m_we  = (m_id >= 0);
      if (m_id >= 0) begin
        m_wd  = {IDW'(m_id), req_dat[m_id*DW +: DW]};
        m_ptr = (m_id + 1) % N;
      end else if (m_phase == 3) begin
        m_ptr = 0;
      end
      if (m_phase == 0) m_phase = s_fsh ? 1 : 0;
      else              m_phase = (m_phase + 1) % 4;
      m_fsh  = (m_phase == 2);
      m_done = (m_phase == 3);
    end
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_dat = '0; fsh_req = 1'b0;
    fifo_ovf = 1'b0; fifo_full = 1'b0; fifo_len = '0;
    s_rst = 1; s_fsh = 0; s_ovf = 0; s_pop = 1; s_vld = '0;

    // reset state
    repeat (3) step();
    s_rst = 0;

    // fairness: everyone valid, FIFO drained every cycle
    s_vld = '1; s_pop = 1;
    repeat (24) step();

    // back-pressure: no pops, requesters 0 and 2
    s_rst = 1; step(); s_rst = 0;
    s_pop = 0; s_vld = 4'b0101; we_cnt = 0;
    repeat (30) step();
    chk("bp_words", 32'(we_cnt), 32'd12);

    // flush pulse with traffic active
    s_rst = 1; step(); s_rst = 0;
    s_pop = 1; s_vld = '1; fsh_cnt = 0; done_cnt = 0;
    repeat (8) step();
    s_fsh = 1; step(); s_fsh = 0;
    repeat (8) step();
    chk("fsh_pulses", 32'(fsh_cnt), 32'd1);
    chk("done_pulses", 32'(done_cnt), 32'd1);

    // held flush request chains flushes back to back
    s_fsh = 1; repeat (6) step(); s_fsh = 0;
    repeat (4) step();

    // reset during the flush pulse cycle: no completion afterwards
    s_fsh = 1; step(); s_fsh = 0;
    step();
    s_rst = 1; step(); s_rst = 0;
    done_cnt = 0;
    repeat (6) step();
    chk("abort_done", 32'(done_cnt), 32'd0);

    // sticky overflow error
    s_ovf = 1; step(); s_ovf = 0;
    repeat (5) step();
    s_rst = 1; step(); s_rst = 0;
    step();

    // random traffic
    repeat (3000) begin
      s_vld = N'($urandom);
      s_pop = ($urandom_range(0, 3) != 0);
      s_fsh = ($urandom_range(0, 40) == 0);
      s_rst = ($urandom_range(0, 250) == 0);
      s_ovf = ($urandom_range(0, 400) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
